// File: rtl/prm_edge_mask_collector.sv
// Collects per-sample edge_mask bits from the PRM checker bank and issues one OR-reduced collision vector per roadmap edge.
// Optional build macro PRM_EARLY_ABORT_EN stops checking an edge's samples once a collision has been seen.
module prm_edge_mask_collector #(
  parameter int NUM_CHK = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic [14:0]        code_data,
  input  logic               code_last,
  output logic [14:0]        chk_code,
  input  logic [NUM_CHK-1:0] chk_mask,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NUM_CHK-1:0] res_mask,
  output logic               res_blocked,
  output logic [CNT_W-1:0]   res_count
);

  localparam int DATA_W = 15;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic               live;
  logic [DATA_W-1:0]  code_p0;
  logic               vld_p1;
  logic               chk_p1;
  logic               last_p1;
  logic [NUM_CHK-1:0] acc_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic               res_valid_q;
  logic [NUM_CHK-1:0] res_mask_q;
  logic               res_blocked_q;
  logic [CNT_W-1:0]   res_count_q;

  logic               code_hs;
  logic               res_hs;
  logic               drive;
  logic               final_p1;
  logic [NUM_CHK-1:0] mask_p1;
  logic [NUM_CHK-1:0] acc_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign code_hs  = code_valid & code_ready;
  assign res_hs   = res_valid_q & res_ready;
  assign final_p1 = vld_p1 & last_p1;

`ifdef PRM_EARLY_ABORT_EN
  // A collision still in stage 1 counts as seen, so the very next sample is already suppressed.
  assign drive = ~((|acc_p1) | (chk_p1 & (|chk_mask)));
`else
  assign drive = 1'b1;
`endif

  // chk_mask only means something for a sample that was actually driven onto the bus.
  assign mask_p1 = chk_p1 ? chk_mask : '0;
  assign acc_nxt = acc_p1 | mask_p1;
  assign cnt_nxt = chk_p1 ? sat_inc(cnt_p1) : cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (code_hs && code_last) state_nxt = DRAIN;
      DRAIN:   if (final_p1)             state_nxt = HOLD;
      HOLD:    if (res_hs)               state_nxt = ACCUM;
      default:                           state_nxt = ACCUM;
    endcase
  end

  // live keeps the sample port closed while reset is asserted.
  always_comb begin
    code_ready = live && (state == ACCUM);
  end

  // Stage 0: register the accepted code onto the checker bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live    <= 1'b0;
      code_p0 <= '0;
      vld_p1  <= 1'b0;
      chk_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      live    <= 1'b1;
      vld_p1  <= code_hs;
      chk_p1  <= code_hs & drive;
      last_p1 <= code_hs & code_last;
      if (code_hs && drive) code_p0 <= code_data;
    end
  end

  // Stage 1: fold the checker mask into the edge accumulator and close out the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1        <= '0;
      cnt_p1        <= '0;
      res_valid_q   <= 1'b0;
      res_mask_q    <= '0;
      res_blocked_q <= 1'b0;
      res_count_q   <= '0;
    end else if (final_p1) begin
      res_mask_q    <= acc_nxt;
      res_blocked_q <= |acc_nxt;
      res_count_q   <= cnt_nxt;
      res_valid_q   <= 1'b1;
      acc_p1        <= '0;
      cnt_p1        <= '0;
    end else begin
      acc_p1 <= acc_nxt;
      cnt_p1 <= cnt_nxt;
      if (res_hs) res_valid_q <= 1'b0;
    end
  end

  assign chk_code    = code_p0;
  assign res_valid   = res_valid_q;
  assign res_mask    = res_mask_q;
  assign res_blocked = res_blocked_q;
  assign res_count   = res_count_q;

endmodule

// File: tb/tb_prm_edge_mask_collector.sv
// Directed bench for prm_edge_mask_collector; the checker bank is modelled as edge_mask = chk_code[7:0].
// Two instances (CNT_W=8 and CNT_W=4) run in lockstep on the same stimulus.
module tb_prm_edge_mask_collector;

  typedef logic [14:0] code_arr_t [32];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        code_valid = 1'b0;
  logic [14:0] code_data = '0;
  logic        code_last = 1'b0;
  logic        res_ready = 1'b0;

  logic        code_ready, res_valid, res_blocked;
  logic [14:0] chk_code;
  logic [7:0]  chk_mask, res_mask, res_count;

  logic        code_ready4, res_valid4, res_blocked4;
  logic [14:0] chk_code4;
  logic [7:0]  chk_mask4, res_mask4;
  logic [3:0]  res_count4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign chk_mask  = chk_code[7:0];
  assign chk_mask4 = chk_code4[7:0];

  prm_edge_mask_collector #(.NUM_CHK(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_ready(code_ready),
    .code_data(code_data), .code_last(code_last), .chk_code(chk_code), .chk_mask(chk_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_mask(res_mask),
    .res_blocked(res_blocked), .res_count(res_count)
  );

  prm_edge_mask_collector #(.NUM_CHK(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_ready(code_ready4),
    .code_data(code_data), .code_last(code_last), .chk_code(chk_code4), .chk_mask(chk_mask4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_mask(res_mask4),
    .res_blocked(res_blocked4), .res_count(res_count4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n samples back to back, leaving time 1ns after the last handshake edge.
  task automatic drive_edge(input code_arr_t codes, input int n, output bit to);
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      code_valid = 1'b1;
      code_data  = codes[i];
      code_last  = (i == n - 1);
      for (int g = 0; g < 40 && !code_ready; g++) step();
      if (!code_ready) begin
        to = 1'b1;
        break;
      end
      step();
    end
    code_valid = 1'b0;
    code_last  = 1'b0;
  endtask

  task automatic ack_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    n_cmp++;
    if ({code_ready, chk_code, res_valid, res_mask, res_blocked, res_count} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {code_ready, chk_code, res_valid, res_mask, res_blocked, res_count});
    end
    #8 rst_n = 1'b1;
    step();
    n_cmp++;
    if (code_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_after_release: got %b want 1", code_ready);
    end
  endtask

  task automatic test_single();
    code_valid = 1'b1;
    code_data  = 15'h4F00;
    code_last  = 1'b1;
    step();
    code_valid = 1'b0;
    code_last  = 1'b0;
    n_cmp++;
    if ({chk_code, res_valid} !== {15'h4F00, 1'b0}) begin
      n_bad++;
      $display("FAIL single_stage0: got code %h valid %b want code 4f00 valid 0", chk_code, res_valid);
    end
    step();
    n_cmp++;
    if ({res_valid, res_mask, res_blocked, res_count, res_count4} !== {1'b1, 8'h00, 1'b0, 8'd1, 4'd1}) begin
      n_bad++;
      $display("FAIL single_result: got v%b m%h b%b c%0d c4 %0d want v1 m00 b0 c1 c4 1",
               res_valid, res_mask, res_blocked, res_count, res_count4);
    end
    ack_result();
    n_cmp++;
    if ({res_valid, code_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL single_release: got valid %b ready %b want 0 1", res_valid, code_ready);
    end
  endtask

  task automatic test_four_sample();
    code_arr_t c;
    bit to;
    c[0] = 15'h1100; c[1] = 15'h1204; c[2] = 15'h1300; c[3] = 15'h1481;
    drive_edge(c, 4, to);
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL four_accept_timeout: got %b want 0", to); end
    n_cmp++;
    if ({code_ready, res_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL four_drain: got ready %b valid %b want 0 0", code_ready, res_valid);
    end
    step();
    n_cmp++;
    if ({res_valid, res_mask, res_blocked, res_count, code_ready} !== {1'b1, 8'h85, 1'b1, 8'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL four_result: got v%b m%h b%b c%0d r%b want v1 m85 b1 c4 r0",
               res_valid, res_mask, res_blocked, res_count, code_ready);
    end
    step();
    n_cmp++;
    if ({res_valid, code_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL four_hold: got valid %b ready %b want 1 0", res_valid, code_ready);
    end
    ack_result();
    n_cmp++;
    if ({res_valid, code_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL four_release: got valid %b ready %b want 0 1", res_valid, code_ready);
    end
  endtask

  task automatic test_backpressure();
    code_arr_t c;
    bit to;
    c[0] = 15'h2001; c[1] = 15'h2002;
    drive_edge(c, 2, to);
    step();
    code_valid = 1'b1;
    code_data  = 15'h3010;
    code_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({res_valid, res_mask, res_blocked, res_count, code_ready, chk_code} !==
          {1'b1, 8'h03, 1'b1, 8'd2, 1'b0, 15'h2002}) begin
        n_bad++;
        $display("FAIL backpressure_hold cycle %0d: got v%b m%h b%b c%0d r%b code %h want v1 m03 b1 c2 r0 code 2002",
                 i, res_valid, res_mask, res_blocked, res_count, code_ready, chk_code);
      end
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_cmp++;
    if ({res_valid, code_ready, chk_code} !== {1'b0, 1'b1, 15'h2002}) begin
      n_bad++;
      $display("FAIL backpressure_release: got v%b r%b code %h want v0 r1 code 2002", res_valid, code_ready, chk_code);
    end
    step();
    code_valid = 1'b0;
    code_last  = 1'b0;
    n_cmp++;
    if (chk_code !== 15'h3010) begin
      n_bad++;
      $display("FAIL backpressure_next_edge: got %h want 3010", chk_code);
    end
    step();
    n_cmp++;
    if ({res_valid, res_mask, res_count} !== {1'b1, 8'h10, 8'd1}) begin
      n_bad++;
      $display("FAIL backpressure_next_result: got v%b m%h c%0d want v1 m10 c1", res_valid, res_mask, res_count);
    end
    ack_result();
  endtask

  task automatic test_saturation();
    code_arr_t c;
    bit to;
    logic [7:0] exp_cnt;
    logic [3:0] exp_cnt4;
    for (int i = 0; i < 20; i++) c[i] = (i == 7) ? 15'h5020 : 15'h5000;
`ifdef PRM_EARLY_ABORT_EN
    exp_cnt  = 8'd8;
    exp_cnt4 = 4'd8;
`else
    exp_cnt  = 8'd20;
    exp_cnt4 = 4'd15;
`endif
    drive_edge(c, 20, to);
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL sat_accept_timeout: got %b want 0", to); end
    step();
    n_cmp++;
    if ({res_valid4, res_mask4, res_blocked4, res_count4} !== {1'b1, 8'h20, 1'b1, exp_cnt4}) begin
      n_bad++;
      $display("FAIL sat_count_w4: got v%b m%h b%b c%0d want v1 m20 b1 c%0d",
               res_valid4, res_mask4, res_blocked4, res_count4, exp_cnt4);
    end
    n_cmp++;
    if ({res_valid, res_count} !== {1'b1, exp_cnt}) begin
      n_bad++;
      $display("FAIL sat_count_w8: got v%b c%0d want v1 c%0d", res_valid, res_count, exp_cnt);
    end
    ack_result();
  endtask

  task automatic test_reset_mid_edge();
    code_arr_t c;
    bit to;
    code_valid = 1'b1;
    code_last  = 1'b0;
    code_data  = 15'h6040;
    step();
    code_data  = 15'h6120;
    step();
    code_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({code_ready, chk_code, res_valid, res_mask, res_count} !== 33'h0) begin
      n_bad++;
      $display("FAIL midreset_clear: got r%b code %h v%b m%h c%0d want all 0",
               code_ready, chk_code, res_valid, res_mask, res_count);
    end
    rst_n = 1'b1;
    step();
    c[0] = 15'h6210; c[1] = 15'h6310;
    drive_edge(c, 2, to);
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL midreset_accept_timeout: got %b want 0", to); end
    step();
    n_cmp++;
    if ({res_valid, res_mask, res_blocked, res_count} !== {1'b1, 8'h10, 1'b1, 8'd2}) begin
      n_bad++;
      $display("FAIL midreset_result: got v%b m%h b%b c%0d want v1 m10 b1 c2",
               res_valid, res_mask, res_blocked, res_count);
    end
    ack_result();
  endtask

  task automatic test_early_abort();
    code_arr_t c;
    bit to;
    logic [7:0]  exp_mask, exp_cnt;
    logic [14:0] exp_code;
    c[0] = 15'h7000; c[1] = 15'h7002; c[2] = 15'h70FF;
    c[3] = 15'h71FF; c[4] = 15'h72FF; c[5] = 15'h73FF;
`ifdef PRM_EARLY_ABORT_EN
    exp_mask = 8'h02; exp_cnt = 8'd2; exp_code = 15'h7002;
`else
    exp_mask = 8'hFF; exp_cnt = 8'd6; exp_code = 15'h73FF;
`endif
    drive_edge(c, 6, to);
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL abort_all_accepted: timeout %b want 0", to); end
    n_cmp++;
    if (chk_code !== exp_code) begin
      n_bad++;
      $display("FAIL abort_bus_code: got %h want %h", chk_code, exp_code);
    end
    step();
    n_cmp++;
    if ({res_valid, res_mask, res_blocked, res_count} !== {1'b1, exp_mask, 1'b1, exp_cnt}) begin
      n_bad++;
      $display("FAIL abort_result: got v%b m%h b%b c%0d want v1 m%h b1 c%0d",
               res_valid, res_mask, res_blocked, res_count, exp_mask, exp_cnt);
    end
    ack_result();
  endtask

  task automatic test_early_ready();
    res_ready  = 1'b1;
    code_valid = 1'b1;
    code_data  = 15'h0005;
    code_last  = 1'b1;
    step();
    code_valid = 1'b0;
    code_last  = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL early_ready_premature: got valid %b want 0", res_valid);
    end
    step();
    n_cmp++;
    if ({res_valid, res_mask, res_count} !== {1'b1, 8'h05, 8'd1}) begin
      n_bad++;
      $display("FAIL early_ready_result: got v%b m%h c%0d want v1 m05 c1", res_valid, res_mask, res_count);
    end
    step();
    res_ready = 1'b0;
    n_cmp++;
    if ({res_valid, code_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL early_ready_release: got valid %b ready %b want 0 1", res_valid, code_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four_sample();
    test_backpressure();
    test_saturation();
    test_reset_mid_edge();
    test_early_abort();
    test_early_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
